program_counter_unit: RTL and testbench
=======================================

Name: program_counter_unit

Overview:
Parametrised full program counter for the CPU core, replacing the separate low/high PC byte registers with one block. Holds the complete PC, split into a low half and a high half. Supports increment, half-loads from the data bus, full jumps from the address inputs, and signed relative branches. A branch that crosses a page takes one extra fix-up cycle on the high half. Drives the address-low bus, the address-high bus and the data bus through registered output stages.

Parameters:
LOW_WIDTH, 8, width of PC low half, data bus and branch offset
HIGH_WIDTH, 8, width of PC high half
RESET_PC, 16'hFFFC, PC value loaded on reset (LOW_WIDTH+HIGH_WIDTH bits)

Ports:
phi2  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
incr_EN  input  1  increment full PC by 1
loadLow_EN  input  1  PC low <= dataBus_IN
loadHigh_EN  input  1  PC high <= dataBus_IN[HIGH_WIDTH-1:0]
jump_EN  input  1  PC <= {addressHigh_IN, addressLow_IN}
branch_EN  input  1  PC low <= PC low + signed dataBus_IN
dataBus_IN  input  LOW_WIDTH  load data / two's-complement branch offset
addressLow_IN  input  LOW_WIDTH  jump target low
addressHigh_IN  input  HIGH_WIDTH  jump target high
addressLow_EN  input  1  capture PC low into addressLowBus_OUT
addressHigh_EN  input  1  capture PC high into addressHighBus_OUT
dataLow_EN  input  1  capture PC low into dataBus_OUT
dataHigh_EN  input  1  capture PC high into dataBus_OUT
addressLowBus_OUT  output  LOW_WIDTH  address-low bus value
addressHighBus_OUT  output  HIGH_WIDTH  address-high bus value
dataBus_OUT  output  LOW_WIDTH  data bus value (high half zero-extended)
pcValue_OUT  output  LOW_WIDTH+HIGH_WIDTH  current PC, combinational from the register
busy_OUT  output  1  high while in FIXUP
pageCross_OUT  output  1  one-cycle pulse during the fix-up cycle

Behaviour:
- Reset (async, any state): PC=RESET_PC; state=IDLE; addressLowBus_OUT, addressHighBus_OUT, dataBus_OUT = 0; busy_OUT=0; pageCross_OUT=0.
- States: IDLE, FIXUP.
- IDLE command priority: jump_EN > branch_EN > (loadLow_EN | loadHigh_EN) > incr_EN. Only the highest-priority active command executes.
  - loadLow_EN and loadHigh_EN together load both halves from dataBus_IN.
- incr: full-width PC+1. The carry from low propagates to high in the same cycle. All-ones wraps to 0.
- branch: sum = {0,PC low} + sign-extended offset, computed at LOW_WIDTH+1 bits. PC low <= sum[LOW_WIDTH-1:0].
  - Positive offset with carry out, or negative offset without carry out: a page cross. Record direction (+1/-1) and go to FIXUP.
  - Otherwise stay in IDLE; the branch completes in 1 cycle.
- FIXUP (exactly 1 cycle): PC high <= PC high ±1, modulo 2^HIGH_WIDTH. busy_OUT=1 and pageCross_OUT=1 for this cycle. All commands are ignored, then return to IDLE.
- Output stages: on each phi2 edge, an output whose enable is high captures the PC value from before that edge's update. If its enable is low it holds.
  - If dataLow_EN and dataHigh_EN are both high, low wins.
  - Enables are honoured in FIXUP too, using the pre-fix-up PC.
- busy_OUT and pageCross_OUT are registered state decodes, so they are valid in the FIXUP cycle itself.
- Reset asserted in FIXUP aborts the fix-up. PC=RESET_PC and no pulse is emitted after release.

Test Plan:
- Reset, then addressLow_EN=addressHigh_EN=1 for one edge: addressLowBus_OUT=8'hFC, addressHighBus_OUT=8'hFF, pcValue_OUT=16'hFFFC.
- jump to 16'h12FF, then incr_EN 2 cycles: pcValue_OUT 16'h1300, then 16'h1301. Repeat from 16'hFFFF: wraps to 16'h0000.
- PC=16'h20F0, branch_EN with offset 8'h20: cycle 1 PC=16'h2010, busy_OUT=1, pageCross_OUT=1; cycle 2 PC=16'h2110, busy_OUT=0. An incr_EN asserted during FIXUP has no effect.
- PC=16'h2005, offset 8'hF0 (-16): PC=16'h20F5, then 16'h1FF5 with pageCross pulse. PC=16'h2040, offset 8'hF0: PC=16'h2030, no FIXUP.
- jump_EN and incr_EN and loadLow_EN in the same cycle, target 16'hABCD: PC=16'hABCD. dataLow_EN and dataHigh_EN together: dataBus_OUT=8'hCD (pre-update value on the following edge).
- Branch causing a page cross, reset asserted mid-FIXUP: PC=16'hFFFC immediately, busy_OUT=0, and no pageCross_OUT pulse after release.

Source files
------------

// File: rtl/program_counter_unit.sv
// Full-width program counter: increment, half loads, jumps and signed relative
// branches with a one-cycle high-half fix-up when a branch crosses a page.
module program_counter_unit #(
   parameter int unsigned LOW_WIDTH  = 8,
   parameter int unsigned HIGH_WIDTH = 8,
   parameter logic [LOW_WIDTH+HIGH_WIDTH-1:0] RESET_PC = 16'hFFFC
) (
   input  logic                             phi2,
   input  logic                             reset,
   input  logic                             incr_EN,
   input  logic                             loadLow_EN,
   input  logic                             loadHigh_EN,
   input  logic                             jump_EN,
   input  logic                             branch_EN,
   input  logic [LOW_WIDTH-1:0]             dataBus_IN,
   input  logic [LOW_WIDTH-1:0]             addressLow_IN,
   input  logic [HIGH_WIDTH-1:0]            addressHigh_IN,
   input  logic                             addressLow_EN,
   input  logic                             addressHigh_EN,
   input  logic                             dataLow_EN,
   input  logic                             dataHigh_EN,
   output logic [LOW_WIDTH-1:0]             addressLowBus_OUT,
   output logic [HIGH_WIDTH-1:0]            addressHighBus_OUT,
   output logic [LOW_WIDTH-1:0]             dataBus_OUT,
   output logic [LOW_WIDTH+HIGH_WIDTH-1:0]  pcValue_OUT,
   output logic                             busy_OUT,
   output logic                             pageCross_OUT
);

   localparam int unsigned PC_WIDTH = LOW_WIDTH + HIGH_WIDTH;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_FIXUP = 1'b1;

   logic [0:0]            state, state_nx;
   logic                  fix_down, fix_down_nx;
   logic [LOW_WIDTH-1:0]  pc_low, pc_low_nx;
   logic [HIGH_WIDTH-1:0] pc_high, pc_high_nx;
   logic [LOW_WIDTH:0]    branch_sum;
   logic [PC_WIDTH-1:0]   pc_incr;
   logic                  offset_neg;

   // Unsigned add exposes the carry; combined with the offset sign it flags a page cross.
   assign branch_sum = {1'b0, pc_low} + {1'b0, dataBus_IN};
   assign offset_neg = dataBus_IN[LOW_WIDTH-1];
   assign pc_incr    = {pc_high, pc_low} + PC_WIDTH'(1);

   // State and PC registers
   always_ff @(posedge phi2 or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         fix_down <= 1'b0;
         pc_low   <= RESET_PC[LOW_WIDTH-1:0];
         pc_high  <= RESET_PC[PC_WIDTH-1:LOW_WIDTH];
      end else begin
         state    <= state_nx;
         fix_down <= fix_down_nx;
         pc_low   <= pc_low_nx;
         pc_high  <= pc_high_nx;
      end
   end

   // Command decode and next-PC selection
   always_comb begin
      state_nx    = state;
      fix_down_nx = fix_down;
      pc_low_nx   = pc_low;
      pc_high_nx  = pc_high;
      case (state)
         S_IDLE: begin
            if (jump_EN) begin
               pc_low_nx  = addressLow_IN;
               pc_high_nx = addressHigh_IN;
            end else if (branch_EN) begin
               pc_low_nx = branch_sum[LOW_WIDTH-1:0];
               if (offset_neg ^ branch_sum[LOW_WIDTH]) begin
                  fix_down_nx = offset_neg;
                  state_nx    = S_FIXUP;
               end
            end else if (loadLow_EN || loadHigh_EN) begin
               if (loadLow_EN)  pc_low_nx  = dataBus_IN;
               if (loadHigh_EN) pc_high_nx = dataBus_IN[HIGH_WIDTH-1:0];
            end else if (incr_EN) begin
               {pc_high_nx, pc_low_nx} = pc_incr;
            end
         end
         default: begin
            pc_high_nx = fix_down ? pc_high - HIGH_WIDTH'(1) : pc_high + HIGH_WIDTH'(1);
            state_nx   = S_IDLE;
         end
      endcase
   end

   // Bus output stages sample the PC as it stood before this edge's update
   always_ff @(posedge phi2 or posedge reset) begin
      if (reset) begin
         addressLowBus_OUT  <= '0;
         addressHighBus_OUT <= '0;
         dataBus_OUT        <= '0;
      end else begin
         if (addressLow_EN)  addressLowBus_OUT  <= pc_low;
         if (addressHigh_EN) addressHighBus_OUT <= pc_high;
         if (dataLow_EN)
            dataBus_OUT <= pc_low;
         else if (dataHigh_EN)
            dataBus_OUT <= LOW_WIDTH'(pc_high);
      end
   end

   assign pcValue_OUT   = {pc_high, pc_low};
   assign busy_OUT      = (state == S_FIXUP);
   assign pageCross_OUT = (state == S_FIXUP);

endmodule

// File: tb/tb_program_counter_unit.sv
// Self-checking bench for program_counter_unit: vector table plus scoreboard,
// with a hand sequence for reset during the fix-up cycle.
module tb_program_counter_unit;

   logic        phi2 = 1'b0;
   logic        reset;
   logic        incr_EN, loadLow_EN, loadHigh_EN, jump_EN, branch_EN;
   logic [7:0]  dataBus_IN, addressLow_IN;
   logic [7:0]  addressHigh_IN;
   logic        addressLow_EN, addressHigh_EN, dataLow_EN, dataHigh_EN;
   logic [7:0]  addressLowBus_OUT, addressHighBus_OUT, dataBus_OUT;
   logic [15:0] pcValue_OUT;
   logic        busy_OUT, pageCross_OUT;

   int passed = 0;
   int total  = 0;

   always #5 phi2 = ~phi2;

   program_counter_unit dut (
      .phi2(phi2), .reset(reset),
      .incr_EN(incr_EN), .loadLow_EN(loadLow_EN), .loadHigh_EN(loadHigh_EN),
      .jump_EN(jump_EN), .branch_EN(branch_EN),
      .dataBus_IN(dataBus_IN), .addressLow_IN(addressLow_IN), .addressHigh_IN(addressHigh_IN),
      .addressLow_EN(addressLow_EN), .addressHigh_EN(addressHigh_EN),
      .dataLow_EN(dataLow_EN), .dataHigh_EN(dataHigh_EN),
      .addressLowBus_OUT(addressLowBus_OUT), .addressHighBus_OUT(addressHighBus_OUT),
      .dataBus_OUT(dataBus_OUT), .pcValue_OUT(pcValue_OUT),
      .busy_OUT(busy_OUT), .pageCross_OUT(pageCross_OUT)
   );

   // cmd = {jump, branch, loadLow, loadHigh, incr}; en = {addrLow, addrHigh, dataLow, dataHigh}
   typedef struct {
      string       name;
      logic [4:0]  cmd;
      logic [7:0]  data;
      logic [15:0] addr;
      logic [3:0]  en;
      logic [15:0] exp_pc;
      logic        exp_busy;
      logic [7:0]  exp_al, exp_ah, exp_db;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   function automatic vec_t mk(string nm, logic [4:0] c, logic [7:0] d, logic [15:0] a,
                               logic [3:0] e, logic [15:0] pc, logic b,
                               logic [7:0] al, logic [7:0] ah, logic [7:0] db);
      vec_t v;
      v.name = nm; v.cmd = c; v.data = d; v.addr = a; v.en = e;
      v.exp_pc = pc; v.exp_busy = b; v.exp_al = al; v.exp_ah = ah; v.exp_db = db;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic drive_idle();
      {jump_EN, branch_EN, loadLow_EN, loadHigh_EN, incr_EN} = 5'b0;
      {addressLow_EN, addressHigh_EN, dataLow_EN, dataHigh_EN} = 4'b0;
      dataBus_IN = 8'h00; addressLow_IN = 8'h00; addressHigh_IN = 8'h00;
   endtask

   task automatic apply(vec_t v);
      {jump_EN, branch_EN, loadLow_EN, loadHigh_EN, incr_EN} = v.cmd;
      {addressLow_EN, addressHigh_EN, dataLow_EN, dataHigh_EN} = v.en;
      dataBus_IN = v.data;
      {addressHigh_IN, addressLow_IN} = v.addr;
      sb.push_back(v);
   endtask

   task automatic compare_front();
      vec_t e;
      e = sb.pop_front();
      chk({e.name, ".pc"},   32'(pcValue_OUT),        32'(e.exp_pc));
      chk({e.name, ".busy"}, 32'(busy_OUT),           32'(e.exp_busy));
      chk({e.name, ".pcx"},  32'(pageCross_OUT),      32'(e.exp_busy));
      chk({e.name, ".al"},   32'(addressLowBus_OUT),  32'(e.exp_al));
      chk({e.name, ".ah"},   32'(addressHighBus_OUT), 32'(e.exp_ah));
      chk({e.name, ".db"},   32'(dataBus_OUT),        32'(e.exp_db));
   endtask

   initial begin
      //            name          cmd     data   addr      en      pc       busy  al     ah     db
      tbl.push_back(mk("rst_cap",  5'b00000, 8'h00, 16'h0000, 4'b1100, 16'hFFFC, 1'b0, 8'hFC, 8'hFF, 8'h00));
      tbl.push_back(mk("jmp12ff",  5'b10000, 8'h00, 16'h12FF, 4'b0000, 16'h12FF, 1'b0, 8'hFC, 8'hFF, 8'h00));
      tbl.push_back(mk("inc1",     5'b00001, 8'h00, 16'h0000, 4'b0000, 16'h1300, 1'b0, 8'hFC, 8'hFF, 8'h00));
      tbl.push_back(mk("inc2",     5'b00001, 8'h00, 16'h0000, 4'b0000, 16'h1301, 1'b0, 8'hFC, 8'hFF, 8'h00));
      tbl.push_back(mk("jmpffff",  5'b10000, 8'h00, 16'hFFFF, 4'b0000, 16'hFFFF, 1'b0, 8'hFC, 8'hFF, 8'h00));
      tbl.push_back(mk("incwrap",  5'b00001, 8'h00, 16'h0000, 4'b0000, 16'h0000, 1'b0, 8'hFC, 8'hFF, 8'h00));
      tbl.push_back(mk("jmp20f0",  5'b10000, 8'h00, 16'h20F0, 4'b0000, 16'h20F0, 1'b0, 8'hFC, 8'hFF, 8'h00));
      tbl.push_back(mk("brfwd",    5'b01000, 8'h20, 16'h0000, 4'b1000, 16'h2010, 1'b1, 8'hF0, 8'hFF, 8'h00));
      tbl.push_back(mk("fixfwd",   5'b00001, 8'h00, 16'h0000, 4'b0100, 16'h2110, 1'b0, 8'hF0, 8'h20, 8'h00));
      tbl.push_back(mk("jmp2005",  5'b10000, 8'h00, 16'h2005, 4'b0000, 16'h2005, 1'b0, 8'hF0, 8'h20, 8'h00));
      tbl.push_back(mk("brback",   5'b01000, 8'hF0, 16'h0000, 4'b0000, 16'h20F5, 1'b1, 8'hF0, 8'h20, 8'h00));
      tbl.push_back(mk("fixback",  5'b00000, 8'h00, 16'h0000, 4'b0010, 16'h1FF5, 1'b0, 8'hF0, 8'h20, 8'hF5));
      tbl.push_back(mk("jmp2040",  5'b10000, 8'h00, 16'h2040, 4'b0000, 16'h2040, 1'b0, 8'hF0, 8'h20, 8'hF5));
      tbl.push_back(mk("brnocx",   5'b01000, 8'hF0, 16'h0000, 4'b0000, 16'h2030, 1'b0, 8'hF0, 8'h20, 8'hF5));
      tbl.push_back(mk("prio",     5'b10101, 8'h55, 16'hABCD, 4'b0000, 16'hABCD, 1'b0, 8'hF0, 8'h20, 8'hF5));
      tbl.push_back(mk("dboth",    5'b00000, 8'h00, 16'h0000, 4'b0011, 16'hABCD, 1'b0, 8'hF0, 8'h20, 8'hCD));
      tbl.push_back(mk("ldboth",   5'b00110, 8'h34, 16'h0000, 4'b0000, 16'h3434, 1'b0, 8'hF0, 8'h20, 8'hCD));
      tbl.push_back(mk("ldhi_inc", 5'b00011, 8'h12, 16'h0000, 4'b0000, 16'h1234, 1'b0, 8'hF0, 8'h20, 8'hCD));
      tbl.push_back(mk("ldlo",     5'b00100, 8'h78, 16'h0000, 4'b0000, 16'h1278, 1'b0, 8'hF0, 8'h20, 8'hCD));
      tbl.push_back(mk("inc_dhi",  5'b00001, 8'h00, 16'h0000, 4'b0001, 16'h1279, 1'b0, 8'hF0, 8'h20, 8'h12));

      drive_idle();
      reset = 1'b1;
      repeat (2) @(posedge phi2);
      #1;
      chk("reset.pc",   32'(pcValue_OUT), 32'hFFFC);
      chk("reset.busy", 32'(busy_OUT), 32'h0);
      chk("reset.db",   32'(dataBus_OUT), 32'h0);
      reset = 1'b0;

      foreach (tbl[i]) begin
         apply(tbl[i]);
         @(posedge phi2);
         #1;
         compare_front();
      end
      drive_idle();

      // Reset asserted in the middle of a fix-up cycle
      apply(mk("j_abort", 5'b10000, 8'h00, 16'h30F0, 4'b0000, 16'h30F0, 1'b0, 8'hF0, 8'h20, 8'h12));
      @(posedge phi2); #1; compare_front();
      apply(mk("br_abort", 5'b01000, 8'h20, 16'h0000, 4'b0000, 16'h3010, 1'b1, 8'hF0, 8'h20, 8'h12));
      @(posedge phi2); #1; compare_front();
      drive_idle();
      #1 reset = 1'b1;
      #1;
      chk("abort.pc",   32'(pcValue_OUT), 32'hFFFC);
      chk("abort.busy", 32'(busy_OUT), 32'h0);
      chk("abort.al",   32'(addressLowBus_OUT), 32'h0);
      @(negedge phi2);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge phi2); #1;
         chk("post_abort.pcx", 32'(pageCross_OUT), 32'h0);
         chk("post_abort.pc",  32'(pcValue_OUT), 32'hFFFC);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
